// File: rtl/adc_pkg.sv
// Shared definitions for the single-slope ADC blocks: the conversion state
// encoding and the default converter width.
package adc_pkg;

  localparam int ADC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RAMP,
    HOLD
  } adc_state_t;

endpackage

// File: rtl/sync_nff.sv
// N-flop synchronizer with asynchronous active-low reset, used to bring
// asynchronous comparator levels into the clk domain.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/ss_adc_capture_ctrl.sv
// Capture controller for a single-slope ADC: clears and releases the ramp
// counter, waits for the comparator trip and presents the corrected code.
module ss_adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int WIDTH       = ADC_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int LAT_COMP    = 2,
  parameter int CLR_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             cmp_async,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_rstn,
  output logic             ramp_en,
  output logic [WIDTH-1:0] code,
  output logic             ovf,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  adc_state_t       state_q, state_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic [WIDTH-1:0] code_d;
  logic             ovf_d, valid_d;
  logic             cmp_s;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sat_code;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_cmp_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (cmp_async),
    .q   (cmp_s)
  );

  // Latency correction in WIDTH+1 bits; a borrow into the top bit means the
  // trip happened before LAT_COMP counts had elapsed, so the code clamps to 0.
  assign diff     = {1'b0, cnt_q} - (WIDTH + 1)'(LAT_COMP);
  assign sat_code = diff[WIDTH] ? '0 : diff[WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      clr_q   <= '0;
      code    <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      code    <= code_d;
      ovf     <= ovf_d;
      valid   <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    code_d   = code;
    ovf_d    = ovf;
    valid_d  = valid;
    cnt_rstn = 1'b0;
    ramp_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr_d   = CLR_W'(CLR_CYCLES - 1);
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_q == '0) begin
          state_d = RAMP;
        end else begin
          clr_d = clr_q - CLR_W'(1);
        end
      end
      RAMP: begin
        cnt_rstn = 1'b1;
        ramp_en  = 1'b1;
        // A trip in the same cycle as full scale is a real measurement, so it wins.
        if (cmp_s) begin
          code_d  = sat_code;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (&cnt_q) begin
          code_d  = '1;
          ovf_d   = 1'b1;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid && ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ss_adc_capture_ctrl.sv
// Self-checking bench for ss_adc_capture_ctrl: directed and randomized
// conversions against a timeline-based model of the conversion rules.
module tb_ss_adc_capture_ctrl;

  localparam int W       = 8;
  localparam int SYNC    = 2;
  localparam int LAT     = 2;
  localparam int CLR     = 2;
  localparam int OVF_IDX = CLR + 2 + 255;
  localparam int NEVER   = 1000000;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         cmp_async = 1'b0;
  logic [W-1:0] cnt_q = '0;
  logic         cnt_rstn;
  logic         ramp_en;
  logic [W-1:0] code;
  logic         ovf;
  logic         valid;
  logic         ready = 1'b0;
  logic         busy;

  int n_cmp = 0;
  int n_fail = 0;
  int last_code = 0;

  ss_adc_capture_ctrl #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .LAT_COMP(LAT), .CLR_CYCLES(CLR)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .cmp_async(cmp_async),
    .cnt_q    (cnt_q),
    .cnt_rstn (cnt_rstn),
    .ramp_en  (ramp_en),
    .code     (code),
    .ovf      (ovf),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Ripple counter model: held at 0 while cleared, counts every clock otherwise.
  always @(posedge clk or negedge cnt_rstn) begin
    if (!cnt_rstn) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "/cnt_rstn"}, cnt_rstn, 0);
    checkOutput({tag, "/ramp_en"}, ramp_en, 0);
    checkOutput({tag, "/code"}, code, 0);
    checkOutput({tag, "/ovf"}, ovf, 0);
    checkOutput({tag, "/valid"}, valid, 0);
    checkOutput({tag, "/busy"}, busy, 0);
  endtask

  // r = negedge index (start negedge is 0) at which cmp_async rises;
  // r < 0 means it is already high before start, NEVER means no trip.
  task automatic applyStimulus(input string tag, input int r, input int hold_cycles,
                               input bit start_in_hold, input bit ready_early);
    int exp_d, exp_code, cnt, j;
    bit exp_ovf, seen;
    if (r < 0) exp_d = CLR + 2;
    else       exp_d = (r + SYNC + 1 > CLR + 2) ? r + SYNC + 1 : CLR + 2;
    if (exp_d <= OVF_IDX) begin
      exp_ovf  = 1'b0;
      cnt      = exp_d - CLR - 2;
      exp_code = (cnt > LAT) ? cnt - LAT : 0;
    end else begin
      exp_d    = OVF_IDX;
      exp_ovf  = 1'b1;
      exp_code = (1 << W) - 1;
    end
    ready = ready_early;
    start = 1'b1;
    j = 0;
    seen = 1'b0;
    while (!seen && j < OVF_IDX + 10) begin
      @(negedge clk);
      j++;
      start = 1'b0;
      if (j == 1) begin
        checkOutput({tag, "/busy_clear"}, busy, 1);
        checkOutput({tag, "/code_held"}, code, last_code);
      end
      if (j == CLR) checkOutput({tag, "/cnt_rstn_clear"}, cnt_rstn, 0);
      if (j == CLR + 1) checkOutput({tag, "/ramp_en_first"}, ramp_en, 1);
      if (valid) seen = 1'b1;
      else if (j == r) cmp_async = 1'b1;
    end
    checkOutput({tag, "/valid_seen"}, seen, 1);
    checkOutput({tag, "/latency"}, j, exp_d);
    checkOutput({tag, "/code"}, code, exp_code);
    checkOutput({tag, "/ovf"}, ovf, exp_ovf);
    checkOutput({tag, "/cnt_rstn_hold"}, cnt_rstn, 0);
    checkOutput({tag, "/ramp_en_hold"}, ramp_en, 0);
    checkOutput({tag, "/busy_hold"}, busy, 1);
    cmp_async = 1'b0;
    for (int k = 0; k < hold_cycles; k++) begin
      ready = 1'b0;
      start = start_in_hold && (k % 3 == 0);
      @(negedge clk);
      checkOutput({tag, "/bp_valid"}, valid, 1);
      checkOutput({tag, "/bp_code"}, code, exp_code);
      checkOutput({tag, "/bp_ovf"}, ovf, exp_ovf);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checkOutput({tag, "/done_valid"}, valid, 0);
    checkOutput({tag, "/done_busy"}, busy, 0);
    checkOutput({tag, "/done_code"}, code, exp_code);
    checkOutput({tag, "/done_ovf"}, ovf, exp_ovf);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput({tag, "/idle_stay"}, busy, 0);
    end
    last_code = exp_code;
  endtask

  initial begin
    int k, c;
    $display("[TB] reset check");
    start = 1'b1;
    cmp_async = 1'b1;
    ready = 1'b1;
    #1;
    checkReset("rst_t0");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkReset("rst_hold");
    end
    rstn = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_valid", valid, 0);
    end
    cmp_async = 1'b0;
    ready = 1'b0;
    repeat (SYNC + 1) @(negedge clk);

    $display("[TB] nominal, overflow, early trip, clamp");
    applyStimulus("nominal", CLR + 1 + 100, 0, 1'b0, 1'b0);
    applyStimulus("overflow", NEVER, 0, 1'b0, 1'b0);
    cmp_async = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    applyStimulus("early_trip", -1, 0, 1'b0, 1'b0);
    applyStimulus("clamp_cnt1", CLR, 0, 1'b0, 1'b0);
    applyStimulus("trip_at_full", CLR + 1 + 253, 0, 1'b0, 1'b0);
    applyStimulus("trip_too_late", CLR + 1 + 254, 0, 1'b0, 1'b0);

    $display("[TB] backpressure with ignored start");
    applyStimulus("backpressure", CLR + 1 + 37, 20, 1'b1, 1'b0);

    $display("[TB] reset mid-ramp");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cnt_q != 8'd50 && k < 300) begin
      @(negedge clk);
      k++;
      checkOutput("mid_no_valid", valid, 0);
    end
    checkOutput("mid_reach50", cnt_q, 50);
    rstn = 1'b0;
    #1;
    checkReset("mid_rst");
    @(negedge clk);
    checkReset("mid_rst_hold");
    rstn = 1'b1;
    last_code = 0;
    @(negedge clk);
    checkOutput("mid_post_busy", busy, 0);
    applyStimulus("after_reset", CLR + 1 + 80, 2, 1'b0, 1'b0);

    $display("[TB] randomized conversions");
    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(0, 253);
      applyStimulus("random", CLR + 1 + c, $urandom_range(0, 5), 1'(i % 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
